// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract controller: drives one full-adder cell (two half
// adders plus an OR) over WIDTH cycles, LSB first, behind start/busy/done.
module half_adder (
   input  logic a_i,
   input  logic b_i,
   output logic s_o,
   output logic c_o
);
   assign s_o = a_i ^ b_i;
   assign c_o = a_i & b_i;
endmodule

module serial_add_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic             sub_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] sum_o,
   output logic             carry_out_o,
   output logic             overflow_o
);
   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d, b_sh_q, b_sh_d;
   logic [WIDTH-1:0] res_q, res_d, sum_q, sum_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             cy_q, cy_d, cout_q, cout_d, ovf_q, ovf_d;
   logic             busy_q, busy_d, done_q, done_d;

   logic             p_bit, g0, g1, s_bit, c_bit;
   logic [WIDTH:0]   res_ext;

   half_adder u_ha0 (.a_i(a_sh_q[0]), .b_i(b_sh_q[0]), .s_o(p_bit), .c_o(g0));
   half_adder u_ha1 (.a_i(p_bit),     .b_i(cy_q),      .s_o(s_bit), .c_o(g1));
   assign c_bit = g0 | g1;

   // New bit enters at the top; after WIDTH shifts the LSB sits at bit 0.
   assign res_ext = {s_bit, res_q};

   always_comb begin
      state_d = state_q;
      a_sh_d  = a_sh_q;
      b_sh_d  = b_sh_q;
      res_d   = res_q;
      sum_d   = sum_q;
      cnt_d   = cnt_q;
      cy_d    = cy_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               a_sh_d  = a_i;
               b_sh_d  = sub_i ? ~b_i : b_i;
               cy_d    = sub_i;
               cnt_d   = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            res_d  = res_ext[WIDTH:1];
            a_sh_d = a_sh_q >> 1;
            b_sh_d = b_sh_q >> 1;
            cy_d   = c_bit;
            cnt_d  = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
               // cy_q is the carry into the MSB here
               sum_d   = res_ext[WIDTH:1];
               cout_d  = c_bit;
               ovf_d   = c_bit ^ cy_q;
               state_d = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         a_sh_q  <= '0;
         b_sh_q  <= '0;
         res_q   <= '0;
         sum_q   <= '0;
         cnt_q   <= '0;
         cy_q    <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_sh_q  <= a_sh_d;
         b_sh_q  <= b_sh_d;
         res_q   <= res_d;
         sum_q   <= sum_d;
         cnt_q   <= cnt_d;
         cy_q    <= cy_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign sum_o       = sum_q;
   assign carry_out_o = cout_q;
   assign overflow_o  = ovf_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl: WIDTH=8 and WIDTH=1 instances checked against an
// arithmetic reference model on directed corners and random operands.
module tb_serial_add_ctrl;
   logic       clk = 1'b0;
   logic       rst8, start8, sub8;
   logic [7:0] a8, b8, sum8;
   logic       busy8, done8, co8, ov8;
   logic       rst1, start1, sub1;
   logic [0:0] a1, b1, sum1;
   logic       busy1, done1, co1, ov1;

   int         n_cmp = 0;
   int         n_fail = 0;
   logic [7:0] exp_sum8 = '0;
   logic       exp_co8 = 1'b0, exp_ov8 = 1'b0;

   always #5 clk = ~clk;

   serial_add_ctrl #(.WIDTH(8)) dut8 (
      .clk_i(clk), .rst_i(rst8), .start_i(start8), .sub_i(sub8), .a_i(a8), .b_i(b8),
      .busy_o(busy8), .done_o(done8), .sum_o(sum8), .carry_out_o(co8), .overflow_o(ov8));

   serial_add_ctrl #(.WIDTH(1)) dut1 (
      .clk_i(clk), .rst_i(rst1), .start_i(start1), .sub_i(sub1), .a_i(a1), .b_i(b1),
      .busy_o(busy1), .done_o(done1), .sum_o(sum1), .carry_out_o(co1), .overflow_o(ov1));

   // Reference: plain modular arithmetic plus the sign rule for overflow.
   function automatic void model(input int w, input longint a, input longint b, input bit s,
                                 output longint sm, output bit co, output bit ov);
      longint mask, full;
      bit sa, sb, ss;
      mask = (longint'(1) << w) - 1;
      full = s ? (a + ((~b) & mask) + 1) : (a + b);
      sm   = full & mask;
      co   = bit'((full >> w) & 1);
      sa   = bit'((a >> (w - 1)) & 1);
      sb   = bit'((b >> (w - 1)) & 1);
      ss   = bit'((sm >> (w - 1)) & 1);
      ov   = s ? ((sa != sb) && (ss != sa)) : ((sa == sb) && (ss != sa));
   endfunction

   // One WIDTH=8 operation starting in the current cycle; inj_cyc > 0 pulses
   // a spurious start with other operands in that RUN cycle.
   task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic s,
                      input int inj_cyc, input string nm);
      longint sm;
      bit co, ov;
      model(8, longint'(a), longint'(b), s, sm, co, ov);
      a8 = a; b8 = b; sub8 = s; start8 = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (busy8 !== 1'b0 || done8 !== 1'b0) begin
         n_fail++; $display("FAIL %s c0 busy/done: got %b%b expected 00", nm, busy8, done8);
      end
      @(posedge clk); #1;
      for (int c = 1; c <= 9; c++) begin
         start8 = (c == inj_cyc);
         a8 = 8'($urandom); b8 = 8'($urandom); sub8 = 1'($urandom);
         @(negedge clk);
         n_cmp++;
         if (busy8 !== 1'b1 || done8 !== (c == 9)) begin
            n_fail++;
            $display("FAIL %s c%0d busy/done: got %b%b expected 1%b", nm, c, busy8, done8, c == 9);
         end
         if (c < 9) begin
            n_cmp++;
            if (sum8 !== exp_sum8 || co8 !== exp_co8 || ov8 !== exp_ov8) begin
               n_fail++;
               $display("FAIL %s c%0d held result: got %h/%b/%b expected %h/%b/%b",
                        nm, c, sum8, co8, ov8, exp_sum8, exp_co8, exp_ov8);
            end
         end else begin
            exp_sum8 = 8'(sm); exp_co8 = co; exp_ov8 = ov;
            n_cmp++;
            if (sum8 !== exp_sum8 || co8 !== exp_co8 || ov8 !== exp_ov8) begin
               n_fail++;
               $display("FAIL %s result %h %s %h: got %h/%b/%b expected %h/%b/%b", nm, a,
                        s ? "-" : "+", b, sum8, co8, ov8, exp_sum8, exp_co8, exp_ov8);
            end
         end
         @(posedge clk); #1;
      end
      start8 = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (busy8 !== 1'b0 || done8 !== 1'b0 || sum8 !== exp_sum8 || co8 !== exp_co8 || ov8 !== exp_ov8) begin
         n_fail++;
         $display("FAIL %s c10 idle: got %b%b %h/%b/%b expected 00 %h/%b/%b", nm, busy8, done8,
                  sum8, co8, ov8, exp_sum8, exp_co8, exp_ov8);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst8 = 1'b1; rst1 = 1'b1; start8 = 1'b1; start1 = 1'b1;
      a8 = 8'h55; b8 = 8'h33; sub8 = 1'b0; a1 = 1'b1; b1 = 1'b1; sub1 = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      start8 = 1'b0; start1 = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({busy8, done8, sum8, co8, ov8} !== 12'h0) begin
         n_fail++; $display("FAIL reset w8: got %b%b %h %b%b expected all 0", busy8, done8, sum8, co8, ov8);
      end
      n_cmp++;
      if ({busy1, done1, sum1, co1, ov1} !== 5'h0) begin
         n_fail++; $display("FAIL reset w1: got %b%b %b %b%b expected all 0", busy1, done1, sum1, co1, ov1);
      end
      @(posedge clk); #1;
      rst8 = 1'b0; rst1 = 1'b0;
   endtask

   task automatic test_corners();
      op8(8'h3C, 8'h05, 1'b0, 0, "add_3c_05");
      op8(8'hFF, 8'h01, 1'b0, 0, "add_ff_01");
      op8(8'h7F, 8'h01, 1'b0, 0, "add_7f_01");
      op8(8'h05, 8'h07, 1'b1, 0, "sub_05_07");
      op8(8'h80, 8'h01, 1'b1, 0, "sub_80_01");
   endtask

   task automatic test_start_ignored();
      op8(8'h10, 8'h20, 1'b0, 4, "busy_start");
   endtask

   task automatic test_mid_reset();
      a8 = 8'hFF; b8 = 8'hFF; sub8 = 1'b0; start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0;
      repeat (4) begin @(posedge clk); #1; end
      // cycle 5: reset together with a start request
      rst8 = 1'b1; start8 = 1'b1; a8 = 8'h12; b8 = 8'h34;
      @(posedge clk); #1;
      rst8 = 1'b0; start8 = 1'b0;
      exp_sum8 = '0; exp_co8 = 1'b0; exp_ov8 = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({busy8, done8, sum8, co8, ov8} !== 12'h0) begin
         n_fail++; $display("FAIL mid_reset c6: got %b%b %h %b%b expected all 0", busy8, done8, sum8, co8, ov8);
      end
      for (int c = 7; c <= 12; c++) begin
         @(negedge clk);
         n_cmp++;
         if (busy8 !== 1'b0 || done8 !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset c%0d quiet: got %b%b expected 00", c, busy8, done8);
         end
      end
      @(posedge clk); #1;
      op8(8'h01, 8'h01, 1'b0, 0, "after_reset");
   endtask

   task automatic test_random();
      for (int i = 0; i < 20; i++)
         op8(8'($urandom), 8'($urandom), 1'($urandom), (i % 3 == 0) ? int'($urandom_range(1, 9)) : 0, "random");
   endtask

   task automatic test_width1();
      logic [0:0] sa, sb;
      logic       ss;
      longint     sm;
      bit         co, ov;
      sa = '0; sb = '0; ss = 1'b0;
      for (int c = 0; c < 15; c++) begin
         start1 = 1'b1;
         if (c == 0) begin a1 = 1'b1; b1 = 1'b1; sub1 = 1'b0; end
         else begin a1 = 1'($urandom); b1 = 1'($urandom); sub1 = 1'($urandom); end
         if (c % 3 == 0) begin sa = a1; sb = b1; ss = sub1; end
         @(negedge clk);
         n_cmp++;
         if (done1 !== (c % 3 == 2) || busy1 !== (c % 3 != 0)) begin
            n_fail++;
            $display("FAIL w1 c%0d busy/done: got %b%b expected %b%b", c, busy1, done1, c % 3 != 0, c % 3 == 2);
         end
         if (c % 3 == 2) begin
            model(1, longint'(sa), longint'(sb), ss, sm, co, ov);
            n_cmp++;
            if (sum1 !== 1'(sm) || co1 !== co || ov1 !== ov) begin
               n_fail++;
               $display("FAIL w1 c%0d result %b%s%b: got %b/%b/%b expected %b/%b/%b", c, sa,
                        ss ? "-" : "+", sb, sum1, co1, ov1, 1'(sm), co, ov);
            end
         end
         @(posedge clk); #1;
      end
      start1 = 1'b0;
   endtask

   initial begin
      test_reset();
      test_corners();
      test_start_ignored();
      test_mid_reset();
      test_random();
      test_width1();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Bit-serial add/subtract controller that sequences a single 1-bit adder cell, built from two `half_adder` instances plus an OR for the carry, over WIDTH clock cycles. It produces a WIDTH-bit sum or difference with carry and signed-overflow flags. The block sits between a requester and the shared adder cell and owns operand capture, bit scheduling, carry storage and result assembly, behind a start/busy/done handshake.

## Interface

**Parameters**
- `WIDTH`, default 8: operand and result width in bits; legal range 1 to 32.

**Ports**
- `clk`, in, 1: the only clock; all logic is rising-edge.
- `rst`, in, 1: reset, synchronous and active-high.
- `start`, in, 1: request to begin an operation; sampled only in IDLE.
- `sub`, in, 1: operation select, 0 = a+b, 1 = a−b; sampled together with `start`.
- `a`, in, WIDTH: first operand; sampled with `start`.
- `b`, in, WIDTH: second operand; sampled with `start`.
- `busy`, out, 1: high while an operation is in progress (RUN or DONE).
- `done`, out, 1: one-cycle completion pulse.
- `sum`, out, WIDTH: result, held until the next completion.
- `carry_out`, out, 1: carry out of the MSB. For subtraction, 1 = no borrow.
- `overflow`, out, 1: two's-complement overflow of the operation.

## Operation

**States:** IDLE, RUN, DONE. Encoding is free.

**IDLE**
- On `start`=1, load `a_sh`←`a` and `b_sh`←(`sub` ? ~`b` : `b`).
- Load `cy`←`sub` and `cnt`←0, then go to RUN.
- `start`=0: stay in IDLE.

**RUN (one bit per cycle, LSB first)**
- Cell: `s = a_sh[0]^b_sh[0]^cy` and `c = (a_sh[0]&b_sh[0]) | ((a_sh[0]^b_sh[0])&cy)`. Use two half-adder stages with the OR of their carries.
- Each edge: `res`←{s, `res`[WIDTH-1:1]}; `a_sh` and `b_sh` shift right by 1; `cy`←c; `cnt`←`cnt`+1.
- When `cnt`==WIDTH−1, the current bit is the MSB:
  - Capture `cmsb`←`cy`, the carry into the MSB.
  - Update `sum`←{s, `res`[WIDTH-1:1]}, `carry_out`←c, `overflow`←c^`cy`.
  - Go to DONE.
- `cnt` width is clog2(WIDTH)+1. WIDTH=1 goes from RUN to DONE after a single cycle.

**DONE**
- `done`=1 for this single cycle, then go to IDLE unconditionally.

**Handshake and boundary rules**
- `start` is ignored in RUN and DONE. There is no queueing; operands are not re-sampled.
- `a`, `b` and `sub` may change freely after the `start` edge.
- `sum`, `carry_out` and `overflow` change only on the RUN→DONE edge. They stay stable through DONE and IDLE until the next completion.
- Arithmetic is modulo 2^WIDTH. Both carry and overflow are always reported, regardless of `sub`.

## Timing

**Reset values**
- Reset forces state=IDLE.
- All outputs reset to 0: `busy`=0, `done`=0, `sum`=0, `carry_out`=0, `overflow`=0.
- `cnt`, `cy`, `a_sh`, `b_sh` and `res` also reset to 0.

**Latency**
- Cycle 0: `start` is high in IDLE and is sampled at the end of cycle 0.
- Cycles 1..WIDTH: state is RUN.
- Cycle WIDTH+1: state is DONE, `done`=1, and the results are valid.
- `busy`=1 for cycles 1..WIDTH+1.
- Minimum issue interval is WIDTH+2 cycles. `start` held high continuously re-triggers at cycle WIDTH+2.

**Reset mid-operation**
- `rst` in any state aborts the operation: no `done` pulse, and outputs return to their reset values on the next edge.
- `start` in the same cycle as `rst` is ignored.

**Outputs** are registered; no combinational path from inputs to outputs.

## Test plan

Unless stated, WIDTH=8, `start` is asserted in cycle 0, and results are checked in the `done` cycle.

1. Add 0x3C+0x05, `sub`=0 → `sum`=0x41, `carry_out`=0, `overflow`=0; `done` high only in cycle 9; `busy` high in cycles 1–9.
2. Carry and overflow corners:
   - 0xFF+0x01 → `sum`=0x00, `carry_out`=1, `overflow`=0.
   - 0x7F+0x01 → `sum`=0x80, `carry_out`=0, `overflow`=1.
3. Subtract corners:
   - 0x05−0x07 → `sum`=0xFE, `carry_out`=0, `overflow`=0.
   - 0x80−0x01 → `sum`=0x7F, `carry_out`=1, `overflow`=1.
4. `start` pulsed in cycle 4 with different operands during a 0x10+0x20 operation → ignored; `sum`=0x30 in cycle 9; operands changed after cycle 0 have no effect.
5. `rst` asserted in cycle 5 of a 0xFF+0xFF operation → cycle 6 shows IDLE with all outputs 0; no `done` pulse. A new 0x01+0x01 started afterwards → `sum`=0x02 after WIDTH+1 cycles.
6. WIDTH=1: inputs 1+1 → `sum`=0, `carry_out`=1, `overflow`=1, `done` in cycle 2. Continuous `start` gives `done` every 3 cycles.
